// File: rtl/led_panel_bcm.sv
// led_panel_bcm: HUB75 scan engine with an internal framebuffer and COLOR_BITS-deep binary-code modulation.
// Define LED_PANEL_DOUBLE_BUFFER_EN for front/back framebuffers swapped at frame end on swap_req.
module led_panel_bcm #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 3,
    parameter int COLOR_BITS = 2,
    parameter int BASE_TIME  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ROW_BITS+$clog2(COLS):0] wr_addr,
    input  logic [3*COLOR_BITS-1:0]        wr_data,
    input  logic                           swap_req,
    output logic [1:0]                     red_out,
    output logic [1:0]                     green_out,
    output logic [1:0]                     blue_out,
    output logic [ROW_BITS-1:0]            addr_out,
    output logic                           sclk_out,
    output logic                           latch_out,
    output logic                           blank_out,
    output logic                           frame_done,
    output logic [1:0]                     o_dbg_state
);

    localparam int COL_W    = $clog2(COLS);
    localparam int AW       = 1 + ROW_BITS + COL_W;
    localparam int DW       = 3 * COLOR_BITS;
    localparam int PLANE_W  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int DISP_MAX = BASE_TIME << (COLOR_BITS - 1);
    localparam int DISP_W   = $clog2(DISP_MAX) + 1;
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
    localparam int FB_AW    = AW + 1;
`else
    localparam int FB_AW    = AW;
`endif
    localparam int FB_WORDS = 1 << FB_AW;

    localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST   = {ROW_BITS{1'b1}};
    localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(COLOR_BITS - 1);
    localparam logic [DISP_W-1:0]   DISP_BASE  = DISP_W'(BASE_TIME);

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [COL_W-1:0]    r_col, w_col_nxt;
    logic                r_phase, w_phase_nxt;
    logic [ROW_BITS-1:0] r_row, w_row_nxt;
    logic [PLANE_W-1:0]  r_plane, w_plane_nxt;
    logic [DISP_W-1:0]   r_disp, w_disp_nxt;
    logic [DISP_W-1:0]   w_disp_last;
    logic                w_frame_end;

    logic                r_sclk, r_latch, r_blank, r_frame_done;
    logic [ROW_BITS-1:0] r_addr;
    logic [1:0]          r_red, r_green, r_blue;

    logic [DW-1:0]       r_fb [0:FB_WORDS-1];
    logic [FB_AW-1:0]    w_rd_top, w_rd_bot, w_wr_idx;
    logic [DW-1:0]       w_pix_top, w_pix_bot;
    logic [COLOR_BITS-1:0] w_top_r, w_top_g, w_top_b, w_bot_r, w_bot_g, w_bot_b;

    assign w_disp_last = (DISP_BASE << r_plane) - DISP_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_phase_nxt = r_phase;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_disp_nxt  = r_disp;
        w_frame_end = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    if (r_col == COL_LAST) begin
                        w_col_nxt   = '0;
                        w_state_nxt = ST_LATCH;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_DISPLAY;
                w_disp_nxt  = '0;
            end
            ST_DISPLAY: begin
                if (r_disp == w_disp_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_disp_nxt  = '0;
                    if (r_plane == PLANE_LAST) begin
                        w_plane_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_row_nxt   = '0;
                            w_frame_end = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_plane_nxt = r_plane + 1'b1;
                    end
                end else begin
                    w_disp_nxt = r_disp + 1'b1;
                end
            end
            default: w_state_nxt = ST_SHIFT;
        endcase
    end

`ifdef LED_PANEL_DOUBLE_BUFFER_EN
    logic r_front, r_pending, w_front_nxt;

    // The frame starting on the swap edge must already read the new front buffer.
    assign w_front_nxt = (w_frame_end && r_pending) ? ~r_front : r_front;
    assign w_rd_top    = {w_front_nxt, 1'b0, w_row_nxt, w_col_nxt};
    assign w_rd_bot    = {w_front_nxt, 1'b1, w_row_nxt, w_col_nxt};
    assign w_wr_idx    = {~r_front, wr_addr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_frame_end && r_pending) begin
            r_front   <= ~r_front;
            r_pending <= swap_req;
        end else if (swap_req) begin
            r_pending <= 1'b1;
        end
    end
`else
    logic w_unused_swap;

    assign w_unused_swap = swap_req;
    assign w_rd_top      = {1'b0, w_row_nxt, w_col_nxt};
    assign w_rd_bot      = {1'b1, w_row_nxt, w_col_nxt};
    assign w_wr_idx      = wr_addr;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) r_fb[w_wr_idx] <= wr_data;
    end

    assign w_pix_top = r_fb[w_rd_top];
    assign w_pix_bot = r_fb[w_rd_bot];
    assign w_top_r   = w_pix_top[3*COLOR_BITS-1:2*COLOR_BITS];
    assign w_top_g   = w_pix_top[2*COLOR_BITS-1:COLOR_BITS];
    assign w_top_b   = w_pix_top[COLOR_BITS-1:0];
    assign w_bot_r   = w_pix_bot[3*COLOR_BITS-1:2*COLOR_BITS];
    assign w_bot_g   = w_pix_bot[2*COLOR_BITS-1:COLOR_BITS];
    assign w_bot_b   = w_pix_bot[COLOR_BITS-1:0];

    // Outputs are registered from the next state, so they always describe the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SHIFT;
            r_col        <= '0;
            r_phase      <= 1'b0;
            r_row        <= '0;
            r_plane      <= '0;
            r_disp       <= '0;
            r_sclk       <= 1'b0;
            r_latch      <= 1'b0;
            r_blank      <= 1'b1;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_phase      <= w_phase_nxt;
            r_row        <= w_row_nxt;
            r_plane      <= w_plane_nxt;
            r_disp       <= w_disp_nxt;
            r_sclk       <= (w_state_nxt == ST_SHIFT) && w_phase_nxt;
            r_latch      <= (w_state_nxt == ST_LATCH);
            r_blank      <= (w_state_nxt != ST_DISPLAY);
            r_frame_done <= w_frame_end;
            if (w_state_nxt == ST_LATCH) r_addr <= r_row;
            if (w_state_nxt == ST_SHIFT) begin
                r_red   <= {w_bot_r[w_plane_nxt], w_top_r[w_plane_nxt]};
                r_green <= {w_bot_g[w_plane_nxt], w_top_g[w_plane_nxt]};
                r_blue  <= {w_bot_b[w_plane_nxt], w_top_b[w_plane_nxt]};
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign red_out     = r_red;
    assign green_out   = r_green;
    assign blue_out    = r_blue;
    assign addr_out    = r_addr;
    assign sclk_out    = r_sclk;
    assign latch_out   = r_latch;
    assign blank_out   = r_blank;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule
